// File: rtl/nubus_memctl_pkg.sv
// Shared types and constants for the NuBus local-memory controller.
package nubus_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR, HOLD} state_e;

  typedef logic [3:0] lane_mask_t;

  localparam lane_mask_t BE_WORD  = 4'b1111;
  localparam lane_mask_t BE_HALF0 = 4'b0011;
  localparam lane_mask_t BE_HALF1 = 4'b1100;
  localparam lane_mask_t BE_NONE  = 4'b0000;

  localparam logic TM1_WRITE = 1'b0;
  localparam logic TM1_READ  = 1'b1;
  localparam logic TM0_BYTE  = 1'b0;
  localparam logic TM0_WIDE  = 1'b1;

  typedef struct packed {
    logic       we;
    lane_mask_t be;
    logic [31:0] wdata;
  } mem_req_t;

  // Timeout counter width: enough for the limit, clamped to 8..16 bits.
  function automatic int tmo_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/nubus_lane_decode.sv
// NuBus TM0/A[1:0] to byte-lane enable decode; flags the reserved half encoding.
module nubus_lane_decode
  import nubus_pkg::*;
(
  input  logic       tm0n_i,
  input  logic [1:0] a_i,
  output lane_mask_t be_o,
  output logic       rsvd_o
);

  always_comb begin
    be_o   = BE_NONE;
    rsvd_o = 1'b0;
    if (tm0n_i == TM0_BYTE) begin
      be_o = lane_mask_t'(4'b0001 << a_i);
    end else begin
      case (a_i)
        2'b00:   be_o = BE_WORD;
        2'b01:   be_o = BE_HALF0;
        2'b11:   be_o = BE_HALF1;
        default: rsvd_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/nubus_memctl.sv
// Registered NuBus slave to card-memory bridge with programmable wait states.
// Optional REQ timeout enabled by defining NUBUS_MEMCTL_TIMEOUT_EN.
module nubus_memctl
  import nubus_pkg::*;
#(
  parameter int MEM_AW         = 22,
  parameter int WAIT_STATES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              nub_clkn,
  input  logic              nub_resetn,
  input  logic [31:0]       nub_adn,
  input  logic              slv_tm1n,
  input  logic              slv_tm0n,
  input  logic              slv_myslotcy,
  input  logic [31:0]       slv_addr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       slv_rdata_n,
  output logic              slv_done,
  output logic              slv_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              slot_q;
  logic [MEM_AW-1:0] addr_q, addr_d;
  mem_req_t          req_q, req_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic [3:0]        wcnt_q, wcnt_d;
  lane_mask_t        dec_be;
  logic              dec_rsvd;
  logic              unused_addr;

  assign unused_addr = ^slv_addr[31:MEM_AW+2];

  nubus_lane_decode u_dec (
    .tm0n_i (slv_tm0n),
    .a_i    (slv_addr[1:0]),
    .be_o   (dec_be),
    .rsvd_o (dec_rsvd)
  );

`ifdef NUBUS_MEMCTL_TIMEOUT_EN
  localparam int TW = tmo_width(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef NUBUS_MEMCTL_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      IDLE: if (slv_myslotcy && !slot_q) begin
        addr_d      = slv_addr[MEM_AW+1:2];
        req_d.be    = dec_be;
        req_d.we    = ~slv_tm1n;
        req_d.wdata = ~nub_adn;
        abort_d     = 1'b0;
`ifdef NUBUS_MEMCTL_TIMEOUT_EN
        tcnt_d      = '0;
`endif
        state_d     = dec_rsvd ? ERR : REQ;
      end
      REQ: begin
        // mem_valid is held through a slot abort; only the handshake ends it.
        if (!slv_myslotcy) abort_d = 1'b1;
        if (mem_ready) begin
          if (!req_q.we) rdata_d = ~mem_rdata;
          wcnt_d  = '0;
          state_d = (WAIT_STATES > 0) ? WAIT : DONE;
        end
`ifdef NUBUS_MEMCTL_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          if (!req_q.we) rdata_d = '1;
          state_d = ERR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      WAIT: begin
        if (!slv_myslotcy) abort_d = 1'b1;
        if (wcnt_q == 4'(WAIT_STATES - 1)) state_d = DONE;
        else wcnt_d = wcnt_q + 4'd1;
      end
      DONE: begin
        done_d  = !abort_q && slv_myslotcy;
        state_d = HOLD;
      end
      ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (!slv_myslotcy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q <= IDLE;
      slot_q  <= 1'b0;
      addr_q  <= '0;
      req_q   <= '0;
      rdata_q <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      wcnt_q  <= '0;
`ifdef NUBUS_MEMCTL_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slv_myslotcy;
      addr_q  <= addr_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      wcnt_q  <= wcnt_d;
`ifdef NUBUS_MEMCTL_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  assign mem_valid   = (state_q == REQ);
  assign busy        = (state_q != IDLE);
  assign mem_we      = req_q.we;
  assign mem_be      = req_q.be;
  assign mem_wdata   = req_q.wdata;
  assign mem_addr    = addr_q;
  assign slv_rdata_n = rdata_q;
  assign slv_done    = done_q;
  assign slv_err     = err_q;

endmodule

// File: tb/tb_nubus_memctl.sv
// Directed bench for nubus_memctl (WAIT_STATES=1, TIMEOUT_CYCLES=8).
module tb_nubus_memctl;

  logic        clk, rstn;
  logic [31:0] adn, addr, mem_rdata, slv_rdata_n, mem_wdata;
  logic        tm1n, tm0n, slot, mem_ready;
  logic        mem_valid, mem_we, slv_done, slv_err, busy;
  logic [3:0]  mem_be;
  logic [21:0] mem_addr;

  int checks = 0;
  int failures = 0;

  nubus_memctl #(.MEM_AW(22), .WAIT_STATES(1), .TIMEOUT_CYCLES(8)) dut (
    .nub_clkn(clk), .nub_resetn(rstn), .nub_adn(adn),
    .slv_tm1n(tm1n), .slv_tm0n(tm0n), .slv_myslotcy(slot), .slv_addr(addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .slv_rdata_n(slv_rdata_n),
    .slv_done(slv_done), .slv_err(slv_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One slot cycle; memory answers on the (d+1)-th valid cycle. lat is the
  // number of clock edges from cycle start to the first observed slv_done.
  task automatic access(input logic t1, input logic t0, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input logic [31:0] rd,
                        output int lat, output int ndone, output int nerr, output int nval,
                        output logic [3:0] be, output logic [21:0] ma,
                        output logic [31:0] mwd, output logic we);
    @(negedge clk);
    tm1n = t1; tm0n = t0; addr = a; adn = ~wd; mem_rdata = rd;
    slot = 1'b1; mem_ready = 1'b0;
    lat = -1; ndone = 0; nerr = 0; nval = 0; be = '0; ma = '0; mwd = '0; we = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 14; k++) begin
      if (mem_valid) begin
        be = mem_be; ma = mem_addr; mwd = mem_wdata; we = mem_we;
        mem_ready = (nval >= d);
        nval++;
      end else begin
        mem_ready = 1'b0;
      end
      if (slv_done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (slv_err) nerr++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic end_cycle();
    @(negedge clk);
    slot = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int lat, nd, ne, nv;
  logic [3:0]  be;
  logic [21:0] ma;
  logic [31:0] wd;
  logic        we;
  logic [3:0]  be_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};
  logic        t0_vec [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0]  a_vec  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};

  initial begin
    rstn = 1'b0; adn = '1; addr = '0; tm1n = 1'b1; tm0n = 1'b1;
    slot = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {slv_done, slv_err}, 0);
    chk("rst_rdata", slv_rdata_n, 32'hFFFF_FFFF);
    chk("rst_be", mem_be, 0);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Word write, zero-wait memory
    access(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0, lat, nd, ne, nv, be, ma, wd, we);
    chk("word_be", be, 4'b1111);
    chk("word_addr", ma, 32'h400);
    chk("word_wdata", wd, 32'hDEAD_BEEF);
    chk("word_we", we, 1);
    chk("word_lat", lat, 3);
    chk("word_ndone", nd, 1);
    chk("word_nval", nv, 1);
    chk("word_nerr", ne, 0);
    chk("word_hold_busy", busy, 1);
    end_cycle();
    chk("word_idle", busy, 0);

    // Byte and half writes
    for (int i = 0; i < 6; i++) begin
      access(1'b0, t0_vec[i], {28'h0000_204, 2'b00, a_vec[i]}, 32'h1122_3344, 0, 32'h0,
             lat, nd, ne, nv, be, ma, wd, we);
      chk($sformatf("lane_be_%0d", i), be, be_exp[i]);
      chk($sformatf("lane_done_%0d", i), nd, 1);
      end_cycle();
    end

    // Read, memory answers after 3 stall cycles
    access(1'b1, 1'b1, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, lat, nd, ne, nv, be, ma, wd, we);
    chk("read_we", we, 0);
    chk("read_addr", ma, 32'h4);
    chk("read_nval", nv, 4);
    chk("read_lat", lat, 6);
    chk("read_ndone", nd, 1);
    chk("read_data", slv_rdata_n, 32'hEDCB_A987);
    end_cycle();
    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0000, 0, 32'h0, lat, nd, ne, nv, be, ma, wd, we);
    chk("read_data_held", slv_rdata_n, 32'hEDCB_A987);
    end_cycle();

    // Reserved encoding
    access(1'b0, 1'b1, 32'h0000_0042, 32'h0, 0, 32'h0, lat, nd, ne, nv, be, ma, wd, we);
    chk("rsvd_nval", nv, 0);
    chk("rsvd_ndone", nd, 1);
    chk("rsvd_nerr", ne, 1);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_hold", busy, 1);
    end_cycle();
    chk("rsvd_idle", busy, 0);

    // Abort: slot drops while REQ is stalled
    @(negedge clk);
    tm1n = 1'b0; tm0n = 1'b1; addr = 32'h20; adn = ~32'h55; slot = 1'b1; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) slot = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_valid_held", mem_valid, 1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("abort_valid_drop", mem_valid, 0);
    nd = 0;
    repeat (6) begin
      if (slv_done) nd++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle", busy, 0);

`ifdef NUBUS_MEMCTL_TIMEOUT_EN
    access(1'b1, 1'b1, 32'h0000_0030, 32'h0, 1000, 32'h0, lat, nd, ne, nv, be, ma, wd, we);
    chk("tmo_nval", nv, 8);
    chk("tmo_nerr", ne, 1);
    chk("tmo_ndone", nd, 1);
    chk("tmo_lat", lat, 9);
    chk("tmo_rdata", slv_rdata_n, 32'hFFFF_FFFF);
    end_cycle();
`endif

    // Reset while REQ is stalled, after a read left non-idle data behind
    access(1'b1, 1'b1, 32'h0000_0010, 32'h0, 0, 32'h0F0F_0F0F, lat, nd, ne, nv, be, ma, wd, we);
    chk("pre_rst_data", slv_rdata_n, 32'hF0F0_F0F0);
    end_cycle();
    @(negedge clk);
    tm1n = 1'b0; tm0n = 1'b1; addr = 32'h40; adn = ~32'h77; slot = 1'b1; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_req_valid", mem_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", mem_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", {slv_done, slv_err}, 0);
    chk("arst_rdata", slv_rdata_n, 32'hFFFF_FFFF);
    chk("arst_be", mem_be, 0);
    @(negedge clk);
    slot = 1'b0;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
